// File: rtl/uart_mmio.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// uart_mmio
// Memory-mapped UART glue plus cycle/instruction counters for a small CPU.
//
// Register map (full 32-bit address compare; other addresses read 0 and
// ignore stores):
//   0x80000000 STATUS (RO) bit0 = TX FIFO not full, bit1 = rx_valid
//   0x80000004 RXDATA (RO) bits 7:0 = rx_data; a load pops the UART byte
//   0x80000008 TXDATA (WO) store with we[0] enqueues wdata[7:0]
//   0x80000010 CYCLE  (RO) free-running cycle counter
//   0x80000014 INSTR  (RO) retired-instruction counter
//   0x80000018 CNTRST (WO) any store clears both counters
//
// Ports:
//   clk, reset          clock and asynchronous active-high reset
//   addr/re/we/wdata    CPU access (we is a byte mask; any bit = store)
//   rdata               registered load data, held until the next load
//   inst_retired        one instruction committed this cycle
//   rx_data/rx_valid    byte offered by the UART receiver
//   rx_ready            combinational pop, pulses on a RXDATA load
//   tx_data/tx_valid    head of the transmit FIFO
//   tx_ready            UART transmitter accepts the head byte
// -----------------------------------------------------------------------------
module uart_mmio #(
  parameter int unsigned TX_FIFO_DEPTH = 4  // power of two, >= 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int PW = $clog2(TX_FIFO_DEPTH);
  localparam int CW = PW + 1;

  localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
  localparam logic [31:0] ADDR_RXDATA = 32'h8000_0004;
  localparam logic [31:0] ADDR_TXDATA = 32'h8000_0008;
  localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] ADDR_INSTR  = 32'h8000_0014;
  localparam logic [31:0] ADDR_CNTRST = 32'h8000_0018;

  // State
  logic [31:0]   rdata_q, rdata_d;
  logic [31:0]   cycle_q, cycle_d;
  logic [31:0]   instr_q, instr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Decode
  logic store_any;
  logic fifo_full;
  logic fifo_empty;
  logic tx_push;
  logic tx_pop;
  logic cnt_clr;
  logic [31:0] load_val;

  // Only the low byte of wdata is ever stored.
  logic unused_wdata;
  assign unused_wdata = ^wdata[31:8];

  assign store_any  = |we;
  assign fifo_full  = (count_q == CW'(TX_FIFO_DEPTH));
  assign fifo_empty = (count_q == '0);

  // Full is judged on the pre-edge count, so a store while full is dropped
  // even if the head leaves on the same edge.
  assign tx_push = we[0] && (addr == ADDR_TXDATA) && !fifo_full;
  assign tx_pop  = !fifo_empty && tx_ready;
  assign cnt_clr = store_any && (addr == ADDR_CNTRST);

  assign rx_ready = re && (addr == ADDR_RXDATA);

  // FIFO storage: one byte register per slot, written at the tail pointer.
  logic [7:0] slots [TX_FIFO_DEPTH];

  generate
    for (genvar gi = 0; gi < TX_FIFO_DEPTH; gi++) begin : g_slot
      logic [7:0] slot_q;
      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          slot_q <= '0;
        end else if (tx_push && (wr_ptr_q == PW'(gi))) begin
          slot_q <= wdata[7:0];
        end
      end
      assign slots[gi] = slot_q;
    end
  endgenerate

  assign tx_data  = slots[rd_ptr_q];
  assign tx_valid = !fifo_empty;

  // Load mux: counters are sampled before any clear on this edge.
  always_comb begin
    load_val = '0;
    case (addr)
      ADDR_STATUS: load_val = {30'd0, rx_valid, !fifo_full};
      ADDR_RXDATA: load_val = {24'd0, rx_data};
      ADDR_CYCLE:  load_val = cycle_q;
      ADDR_INSTR:  load_val = instr_q;
      default:     load_val = '0;
    endcase
  end

  always_comb begin
    rdata_d  = re ? load_val : rdata_q;

    wr_ptr_d = tx_push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = tx_pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    if (tx_push && !tx_pop) begin
      count_d = count_q + CW'(1);
    end else if (!tx_push && tx_pop) begin
      count_d = count_q - CW'(1);
    end

    if (cnt_clr) begin
      cycle_d = '0;
      instr_d = '0;
    end else begin
      cycle_d = cycle_q + 32'd1;
      instr_d = instr_q + {31'd0, inst_retired};
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdata_q  <= '0;
      cycle_q  <= '0;
      instr_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rdata_q  <= rdata_d;
      cycle_q  <= cycle_d;
      instr_q  <= instr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata = rdata_q;

endmodule

// File: tb/tb_uart_mmio.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_uart_mmio
// Self-checking bench for uart_mmio. A behavioural model (byte queue, two
// integer counters, a held load value) tracks what the register map should
// return; directed scenarios are followed by randomized traffic.
// -----------------------------------------------------------------------------
module tb_uart_mmio;

  localparam int DEPTH = 4;

  localparam logic [31:0] A_STATUS = 32'h8000_0000;
  localparam logic [31:0] A_RXDATA = 32'h8000_0004;
  localparam logic [31:0] A_TXDATA = 32'h8000_0008;
  localparam logic [31:0] A_HOLE   = 32'h8000_000C;
  localparam logic [31:0] A_CYCLE  = 32'h8000_0010;
  localparam logic [31:0] A_INSTR  = 32'h8000_0014;
  localparam logic [31:0] A_CNTRST = 32'h8000_0018;
  localparam logic [31:0] A_UNMAP  = 32'h8000_0020;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        inst_retired;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;

  always #5 clk = ~clk;

  uart_mmio #(.TX_FIFO_DEPTH(DEPTH)) dut (
    .clk          (clk),
    .reset        (reset),
    .addr         (addr),
    .re           (re),
    .we           (we),
    .wdata        (wdata),
    .rdata        (rdata),
    .inst_retired (inst_retired),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model
  logic [7:0]  m_fifo [$];
  logic [31:0] m_cycle;
  logic [31:0] m_instr;
  logic [31:0] m_rdata;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [31:0] a);
    case (a)
      A_STATUS: return {30'd0, rx_valid, (m_fifo.size() != DEPTH)};
      A_RXDATA: return {24'd0, rx_data};
      A_CYCLE:  return m_cycle;
      A_INSTR:  return m_instr;
      default:  return 32'd0;
    endcase
  endfunction

  task automatic model_reset();
    m_fifo.delete();
    m_cycle = 32'd0;
    m_instr = 32'd0;
    m_rdata = 32'd0;
  endtask

  // One clock: inputs are already driven (called right after a falling edge).
  // Checks pre-edge outputs, advances the model, then checks rdata after the edge.
  task automatic tick();
    bit full;
    #1;
    check_eq("rx_ready", {31'd0, rx_ready}, {31'd0, (re && addr == A_RXDATA)});
    check_eq("tx_valid", {31'd0, tx_valid}, {31'd0, (m_fifo.size() != 0)});
    if (m_fifo.size() != 0)
      check_eq("tx_data", {24'd0, tx_data}, {24'd0, m_fifo[0]});

    if (re) m_rdata = m_load(addr);
    full = (m_fifo.size() == DEPTH);
    if (tx_ready && m_fifo.size() != 0) void'(m_fifo.pop_front());
    if (addr == A_TXDATA && we[0] && !full) m_fifo.push_back(wdata[7:0]);
    if (addr == A_CNTRST && we != 4'd0) begin
      m_cycle = 32'd0;
      m_instr = 32'd0;
    end else begin
      m_cycle = m_cycle + 32'd1;
      m_instr = m_instr + {31'd0, inst_retired};
    end

    @(posedge clk);
    #1;
    check_eq("rdata", rdata, m_rdata);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    re = 1'b0; we = 4'd0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_load(input logic [31:0] a);
    addr = a; re = 1'b1; we = 4'd0;
    tick();
    re = 1'b0;
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] m);
    addr = a; wdata = d; we = m; re = 1'b0;
    tick();
    we = 4'd0;
  endtask

  // Guard against a hung run.
  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    reset = 1'b1;
    addr = 32'd0; re = 1'b0; we = 4'd0; wdata = 32'd0;
    inst_retired = 1'b0; rx_data = 8'd0; rx_valid = 1'b0; tx_ready = 1'b0;
    model_reset();

    // Reset state
    #1;
    check_eq("rst_rdata", rdata, 32'd0);
    check_eq("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("rst_tx_data", {24'd0, tx_data}, 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    // First edge after reset: CYCLE still reads 0, next read 1.
    do_load(A_CYCLE);
    check_eq("cycle_first", rdata, 32'd0);
    do_load(A_CYCLE);
    check_eq("cycle_second", rdata, 32'd1);

    // Echo path
    rx_data = 8'h7A; rx_valid = 1'b1;
    do_load(A_STATUS);
    check_eq("echo_status", rdata, 32'h3);
    do_load(A_RXDATA);
    check_eq("echo_rxdata", rdata, 32'h7A);
    rx_valid = 1'b0;
    idle(1);                         // rx_ready must be low again
    do_store(A_TXDATA, 32'h0000_007A, 4'b0001);
    check_eq("echo_tx_valid", {31'd0, tx_valid}, 32'd1);
    check_eq("echo_tx_data", {24'd0, tx_data}, 32'h7A);
    tx_ready = 1'b1;
    idle(1);
    tx_ready = 1'b0;

    // Backpressure: five stores into a four-entry FIFO
    for (int i = 0; i < 4; i++) do_store(A_TXDATA, 32'h41 + i, 4'b0001);
    do_load(A_STATUS);
    check_eq("bp_status_full", rdata & 32'h1, 32'h0);
    do_store(A_TXDATA, 32'h45, 4'b0001);
    tx_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check_eq("bp_drain_valid", {31'd0, tx_valid}, 32'd1);
      check_eq("bp_drain_data", {24'd0, tx_data}, 32'h41 + i);
      tick();
    end
    check_eq("bp_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Full plus simultaneous dequeue: the store is dropped
    for (int i = 0; i < 4; i++) do_store(A_TXDATA, 32'h60 + i, 4'b0001);
    tx_ready = 1'b1;
    do_store(A_TXDATA, 32'h55, 4'b0001);
    tx_ready = 1'b0;
    do_load(A_STATUS);
    check_eq("fd_not_full", rdata & 32'h1, 32'h1);
    tx_ready = 1'b1;
    for (int i = 1; i < 4; i++) begin
      #1;
      check_eq("fd_drain_data", {24'd0, tx_data}, 32'h60 + i);
      tick();
    end
    check_eq("fd_empty", {31'd0, tx_valid}, 32'd0);
    tx_ready = 1'b0;

    // Counters and clear
    inst_retired = 1'b1;
    idle(10);
    do_store(A_CNTRST, 32'd0, 4'b0010);
    do_load(A_CYCLE);
    check_eq("clr_cycle", rdata, 32'd0);
    do_load(A_INSTR);
    check_eq("clr_instr", rdata, 32'd1);
    inst_retired = 1'b0;

    // Cycle counter wrap
    force dut.cycle_q = 32'hFFFF_FFFF;
    #1;
    release dut.cycle_q;
    m_cycle = 32'hFFFF_FFFF;
    do_load(A_CYCLE);
    check_eq("wrap_max", rdata, 32'hFFFF_FFFF);
    do_load(A_CYCLE);
    check_eq("wrap_zero", rdata, 32'd0);

    // Unmapped addresses
    do_load(A_UNMAP);
    check_eq("unmapped_load", rdata, 32'd0);
    do_store(A_HOLE, 32'hFFFF_FFFF, 4'b1111);
    do_load(A_HOLE);
    check_eq("hole_load", rdata, 32'd0);

    // Asynchronous reset with three bytes queued
    for (int i = 0; i < 3; i++) do_store(A_TXDATA, 32'h90 + i, 4'b0001);
    do_load(A_STATUS);
    check_eq("ar_status", rdata, 32'h1);
    #2;
    reset = 1'b1;
    #1;
    check_eq("ar_tx_valid", {31'd0, tx_valid}, 32'd0);
    check_eq("ar_rdata", rdata, 32'd0);
    model_reset();
    @(negedge clk);
    reset = 1'b0;
    do_load(A_CYCLE);
    check_eq("ar_cycle", rdata, 32'd0);

    // Randomized traffic
    for (int n = 0; n < 600; n++) begin
      case ($urandom_range(0, 8))
        0: addr = A_STATUS;
        1: addr = A_RXDATA;
        2, 3: addr = A_TXDATA;
        4: addr = A_CYCLE;
        5: addr = A_INSTR;
        6: addr = ($urandom_range(0, 3) == 0) ? A_CNTRST : A_HOLE;
        7: addr = A_UNMAP;
        default: addr = $urandom;
      endcase
      re           = 1'($urandom_range(0, 1));
      we           = ($urandom_range(0, 1) == 1) ? 4'($urandom) : 4'd0;
      wdata        = $urandom;
      tx_ready     = ($urandom_range(0, 2) == 0);
      inst_retired = 1'($urandom_range(0, 1));
      rx_valid     = 1'($urandom_range(0, 1));
      rx_data      = 8'($urandom);
      tick();
    end
    re = 1'b0; we = 4'd0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
